// File: rtl/char_draw_ctrl.sv
// -----------------------------------------------------------------------------
// char_draw_ctrl
//
// Renders one character glyph into the framebuffer. A start request latches the
// cell origin and character code. The block then sweeps a CELL_W x CELL_H cell
// in row-major order, driving the shared glyph decoder bank with absolute
// coordinates (flush_x/flush_y). Decoder hits become registered plot writes
// that honour plot_ready backpressure.
//
// Optional feature macro: CHAR_BG_FILL_EN
//   defined   : every cell pixel is written; misses use BG_COLOUR, so any old
//               glyph in the cell is erased.
//   undefined : only glyph hits are written and the background is untouched.
//
// Ports
//   clk, resetn          rising-edge clock, asynchronous active-low reset
//   start                draw request, sampled only in IDLE
//   char_x, char_y       cell origin
//   char_code            character select
//   busy                 high while the cell is swept and the last write drains
//   done                 one-cycle completion pulse
//   glyph_sel/x/y        latched code/origin, fed to the external decoder mux
//   flush_x, flush_y     current absolute pixel (origin + dx/dy, mod 256)
//   glyph_colour/enable  decoder response, combinational from flush_x/flush_y
//   plot, plot_x/y       registered framebuffer write strobe and address
//   plot_colour          registered write colour
//   plot_ready           framebuffer accepts the write presented this cycle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module char_draw_ctrl #(
    parameter int          CELL_W    = 10,
    parameter int          CELL_H    = 10,
    parameter int          CODE_W    = 6,
    parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [7:0]        char_x,
    input  logic [7:0]        char_y,
    input  logic [CODE_W-1:0] char_code,
    output logic              busy,
    output logic              done,
    output logic [CODE_W-1:0] glyph_sel,
    output logic [7:0]        glyph_x,
    output logic [7:0]        glyph_y,
    output logic [7:0]        flush_x,
    output logic [7:0]        flush_y,
    input  logic [5:0]        glyph_colour,
    input  logic              glyph_enable,
    output logic              plot,
    output logic [7:0]        plot_x,
    output logic [7:0]        plot_y,
    output logic [5:0]        plot_colour,
    input  logic              plot_ready
);

    localparam int DX_W = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int DY_W = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam logic [DX_W-1:0] DX_LAST = DX_W'(CELL_W - 1);
    localparam logic [DY_W-1:0] DY_LAST = DY_W'(CELL_H - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q,       state_d;
    logic [DX_W-1:0]     dx_q,          dx_d;
    logic [DY_W-1:0]     dy_q,          dy_d;
    logic [CODE_W-1:0]   glyph_sel_q,   glyph_sel_d;
    logic [7:0]          glyph_x_q,     glyph_x_d;
    logic [7:0]          glyph_y_q,     glyph_y_d;
    logic                plot_q,        plot_d;
    logic [7:0]          plot_x_q,      plot_x_d;
    logic [7:0]          plot_y_q,      plot_y_d;
    logic [5:0]          plot_colour_q, plot_colour_d;

    logic                stall;
    logic                pix_write;
    logic [5:0]          pix_colour;

    // Absolute pixel address; 8-bit wrap is intended (no clipping at 255).
    assign flush_x = glyph_x_q + 8'(dx_q);
    assign flush_y = glyph_y_q + 8'(dy_q);

    // A presented write that the framebuffer refuses freezes the sweep.
    assign stall = plot_q & ~plot_ready;

    // Colour is chosen for every pixel; without background fill a miss simply
    // does not assert plot, so the colour register content is irrelevant then.
    assign pix_colour = glyph_enable ? glyph_colour : BG_COLOUR;
`ifdef CHAR_BG_FILL_EN
    assign pix_write  = 1'b1;
`else
    assign pix_write  = glyph_enable;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case
        // leaves a variable unassigned, which would infer a latch.
        state_d       = state_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        glyph_sel_d   = glyph_sel_q;
        glyph_x_d     = glyph_x_q;
        glyph_y_d     = glyph_y_q;
        plot_d        = plot_q;
        plot_x_d      = plot_x_q;
        plot_y_d      = plot_y_q;
        plot_colour_d = plot_colour_q;

        unique case (state_q)
            IDLE: begin
                plot_d = 1'b0;
                if (start) begin
                    glyph_sel_d = char_code;
                    glyph_x_d   = char_x;
                    glyph_y_d   = char_y;
                    dx_d        = '0;
                    dy_d        = '0;
                    state_d     = SCAN;
                end
            end

            SCAN: begin
                if (!stall) begin
                    plot_d        = pix_write;
                    plot_x_d      = flush_x;
                    plot_y_d      = flush_y;
                    plot_colour_d = pix_colour;
                    if (dx_q == DX_LAST) begin
                        dx_d = '0;
                        if (dy_q == DY_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            dy_d = dy_q + DY_W'(1);
                        end
                    end else begin
                        dx_d = dx_q + DX_W'(1);
                    end
                end
            end

            // The last pixel's write is still on the port; wait for acceptance.
            DRAIN: begin
                if (!stall) begin
                    plot_d  = 1'b0;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            dx_q          <= '0;
            dy_q          <= '0;
            glyph_sel_q   <= '0;
            glyph_x_q     <= '0;
            glyph_y_q     <= '0;
            plot_q        <= 1'b0;
            plot_x_q      <= '0;
            plot_y_q      <= '0;
            plot_colour_q <= '0;
        end else begin
            state_q       <= state_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            glyph_sel_q   <= glyph_sel_d;
            glyph_x_q     <= glyph_x_d;
            glyph_y_q     <= glyph_y_d;
            plot_q        <= plot_d;
            plot_x_q      <= plot_x_d;
            plot_y_q      <= plot_y_d;
            plot_colour_q <= plot_colour_d;
        end
    end

    assign busy        = (state_q == SCAN) || (state_q == DRAIN);
    assign done        = (state_q == DONE);
    assign glyph_sel   = glyph_sel_q;
    assign glyph_x     = glyph_x_q;
    assign glyph_y     = glyph_y_q;
    assign plot        = plot_q;
    assign plot_x      = plot_x_q;
    assign plot_y      = plot_y_q;
    assign plot_colour = plot_colour_q;

endmodule

// File: tb/tb_char_draw_ctrl.sv
// -----------------------------------------------------------------------------
// tb_char_draw_ctrl
//
// Bench for char_draw_ctrl. It emulates the glyph decoder bank (combinational
// from flush_x/flush_y relative to the latched origin) and keeps a list of the
// writes each character must produce, derived by walking the cell row by row.
// A negedge monitor compares every accepted write against that list.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_char_draw_ctrl;

    localparam int         CELL_W = 10;
    localparam int         CELL_H = 10;
    localparam int         CODE_W = 6;
    localparam int         NPIX   = CELL_W * CELL_H;
    localparam logic [5:0] BG     = 6'b000000;
    localparam logic [5:0] L_CODE = 6'd11;

    typedef logic [21:0] wr_t;   // {x, y, colour}

    logic              clk;
    logic              resetn;
    logic              start;
    logic [7:0]        char_x;
    logic [7:0]        char_y;
    logic [CODE_W-1:0] char_code;
    logic              busy;
    logic              done;
    logic [CODE_W-1:0] glyph_sel;
    logic [7:0]        glyph_x;
    logic [7:0]        glyph_y;
    logic [7:0]        flush_x;
    logic [7:0]        flush_y;
    logic [5:0]        glyph_colour;
    logic              glyph_enable;
    logic              plot;
    logic [7:0]        plot_x;
    logic [7:0]        plot_y;
    logic [5:0]        plot_colour;
    logic              plot_ready;

    char_draw_ctrl #(
        .CELL_W   (CELL_W),
        .CELL_H   (CELL_H),
        .CODE_W   (CODE_W),
        .BG_COLOUR(BG)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .char_x      (char_x),
        .char_y      (char_y),
        .char_code   (char_code),
        .busy        (busy),
        .done        (done),
        .glyph_sel   (glyph_sel),
        .glyph_x     (glyph_x),
        .glyph_y     (glyph_y),
        .flush_x     (flush_x),
        .flush_y     (flush_y),
        .glyph_colour(glyph_colour),
        .glyph_enable(glyph_enable),
        .plot        (plot),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot_ready  (plot_ready)
    );

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  acc_cnt, stall_cnt, busy_cnt, done_cnt;
    bit  mon_en = 0;
    int  rdy_mode = 0;      // 0: always ready, 1: random, 2: 5-cycle hold on 3rd write
    int  hold_left = 0;
    int  last_lat = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- glyph decoder emulation ----------------
    // 'l': vertical stroke at dx=3 for dy=0..8, foot at dy=9 for dx=3..7.
    function automatic bit glyph_hit(input logic [5:0] code, input int dx, input int dy);
        if (dx >= CELL_W || dy >= CELL_H) return 1'b0;
        if (code == L_CODE) return (dx == 3 && dy <= 8) || (dy == 9 && dx >= 3 && dx <= 7);
        return ((dx * 3 + dy * 5 + int'(code)) % 7) < 2;
    endfunction

    function automatic logic [5:0] glyph_col(input logic [5:0] code, input int dx, input int dy);
        if (code == L_CODE) return 6'h3f;
        return 6'(int'(code) + dx * 4 + dy) | 6'h01;
    endfunction

    logic [7:0] rel_x, rel_y;
    assign rel_x = flush_x - glyph_x;
    assign rel_y = flush_y - glyph_y;

    always_comb begin
        glyph_enable = glyph_hit(glyph_sel, int'(rel_x), int'(rel_y));
        glyph_colour = glyph_col(glyph_sel, int'(rel_x), int'(rel_y));
    end

    // ---------------- reference model ----------------
    task automatic build_expected(input logic [5:0] code, input logic [7:0] ox, input logic [7:0] oy);
        exp_q.delete();
        for (int dy = 0; dy < CELL_H; dy++) begin
            for (int dx = 0; dx < CELL_W; dx++) begin
                logic [7:0] px;
                logic [7:0] py;
                px = 8'(int'(ox) + dx);
                py = 8'(int'(oy) + dy);
                if (glyph_hit(code, dx, dy))
                    exp_q.push_back({px, py, glyph_col(code, dx, dy)});
`ifdef CHAR_BG_FILL_EN
                else
                    exp_q.push_back({px, py, BG});
`endif
            end
        end
    endtask

    // ---------------- plot_ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1: plot_ready = ($urandom % 4) != 0;
            2: begin
                if (plot && acc_cnt == 2 && hold_left > 0) begin
                    plot_ready = 1'b0;
                    hold_left--;
                end else begin
                    plot_ready = 1'b1;
                end
            end
            default: plot_ready = 1'b1;
        endcase
    end

    // ---------------- compare process ----------------
    initial begin
        bit         prev_stall;
        logic [22:0] prev_out;
        wr_t        w;
        wr_t        e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_stall = 1'b0;
            end else if (mon_en) begin
                if (prev_stall)
                    check("stall_hold", 32'({plot, plot_x, plot_y, plot_colour}), 32'(prev_out));
                if (plot && plot_ready) begin
                    w = {plot_x, plot_y, plot_colour};
                    got_q.push_back(w);
                    acc_cnt++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL write_extra: got 0x%0h expected no write", w);
                    end else begin
                        e = exp_q.pop_front();
                        check("write", 32'(w), 32'(e));
                    end
                end
                if (plot && !plot_ready) stall_cnt++;
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    check("done_busy_low", 32'(busy), 32'(0));
                end
                prev_stall = plot && !plot_ready;
                prev_out   = {plot, plot_x, plot_y, plot_colour};
            end
        end
    end

    // Issue one character and wait (bounded) for done. With inject set, a
    // start with a different code/origin is pulsed mid-sweep.
    task automatic run_char(input logic [5:0] code, input logic [7:0] x, input logic [7:0] y,
                            input bit inject);
        int t0;
        int exp_n;
        bit seen;
        build_expected(code, x, y);
        exp_n = exp_q.size();
        got_q.delete();
        acc_cnt = 0; stall_cnt = 0; busy_cnt = 0; done_cnt = 0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; char_code = code; char_x = x; char_y = y;
        @(posedge clk); #1;
        t0 = cyc;
        start = 1'b0;
        char_code = 6'($urandom); char_x = 8'($urandom); char_y = 8'($urandom);
        seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            if (inject && n == 30) begin
                start = 1'b1; char_code = code ^ 6'h15; char_x = x + 8'd77; char_y = y + 8'd33;
            end else if (inject && n == 31) begin
                start = 1'b0;
            end
        end
        check("done_seen", 32'(seen), 32'(1));
        last_lat = cyc - t0;
        check("latency", 32'(last_lat), 32'(NPIX + 1 + stall_cnt));
        repeat (3) @(posedge clk);
        #1;
        check("busy_cycles", 32'(busy_cnt), 32'(last_lat));
        check("done_pulses", 32'(done_cnt), 32'(1));
        check("writes_left", 32'(exp_q.size()), 32'(0));
        check("write_count", 32'(got_q.size()), 32'(exp_n));
        check("glyph_latch", 32'({glyph_sel, glyph_x, glyph_y}), 32'({code, x, y}));
    endtask

    initial begin
        wr_t w;
        int  n_hit;
        int  n_bg;
        int  base;
        int  bx [5];
        bit  found;
        bx = '{253, 254, 255, 0, 1};

        resetn = 1'b0; start = 1'b0;
        char_x = '0; char_y = '0; char_code = '0;
        plot_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_plot",  32'(plot), 32'(0));
        check("rst_busy",  32'(busy), 32'(0));
        check("rst_done",  32'(done), 32'(0));
        check("rst_glyph", 32'({glyph_sel, glyph_x, glyph_y}), 32'(0));
        check("rst_plotv", 32'({plot_x, plot_y, plot_colour}), 32'(0));
        check("rst_flush", 32'({flush_x, flush_y}), 32'(0));
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: letter 'l' at (20,30)
        run_char(L_CODE, 8'd20, 8'd30, 1'b0);
        check("t1_latency", 32'(last_lat), 32'(101));
`ifdef CHAR_BG_FILL_EN
        n_hit = 0; n_bg = 0;
        foreach (got_q[i]) begin
            w = got_q[i];
            if (w[5:0] == 6'h3f) n_hit++;
            else if (w[5:0] == BG) n_bg++;
        end
        check("t1_count", 32'(got_q.size()), 32'(100));
        check("t1_hits",  32'(n_hit), 32'(14));
        check("t1_bg",    32'(n_bg), 32'(86));
        base = 93;
        w = (got_q.size() > 3) ? got_q[3] : '0;
`else
        n_hit = 0; n_bg = 0;
        check("t1_count", 32'(got_q.size()), 32'(14));
        base = 9;
        w = (got_q.size() > 0) ? got_q[0] : '0;
`endif
        check("t1_first", 32'(w), 32'({8'd23, 8'd30, 6'h3f}));
        w = (got_q.size() > 0) ? got_q[base + 4] : '0;
        check("t1_last", 32'(w), 32'({8'd27, 8'd39, 6'h3f}));

        // 2: wrap at x=250
        run_char(L_CODE, 8'd250, 8'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            w = (got_q.size() > base + i) ? got_q[base + i] : '0;
            check("t2_bottom_row", 32'(w[21:6]), 32'({8'(bx[i]), 8'd9}));
        end
        w = (got_q.size() > 0) ? got_q[base - 9 * (base == 9 ? 1 : 0) + (base == 9 ? 0 : -90)] : '0;
        check("t2_column_top", 32'(w[21:6]), 32'({8'd253, 8'd0}));

        // 3: backpressure of 5 cycles on the 3rd write
        rdy_mode = 2; hold_left = 5;
        run_char(L_CODE, 8'd40, 8'd50, 1'b0);
        check("t3_stalls",  32'(stall_cnt), 32'(5));
        check("t3_latency", 32'(last_lat), 32'(106));
        rdy_mode = 0;

        // 4: start pulsed while busy is ignored
        run_char(6'd3, 8'd100, 8'd120, 1'b1);

        // 5: reset in the middle of a sweep
        build_expected(L_CODE, 8'd60, 8'd70);
        done_cnt = 0; mon_en = 1'b1;
        @(posedge clk); #1;
        start = 1'b1; char_code = L_CODE; char_x = 8'd60; char_y = 8'd70;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        found = 1'b0;
        for (int n = 0; n < 60 && !found; n++) begin
            @(negedge clk);
            if (plot) found = 1'b1;
        end
        check("t5_plot_before", 32'(plot), 32'(1));
        #2;
        resetn = 1'b0;
        #1;
        check("t5_async_plot", 32'(plot), 32'(0));
        check("t5_async_busy", 32'(busy), 32'(0));
        check("t5_async_done", 32'(done), 32'(0));
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_idle", 32'({busy, done, plot, glyph_x}), 32'(0));
        check("t5_no_done", 32'(done_cnt), 32'(0));
        run_char(L_CODE, 8'd60, 8'd70, 1'b0);

        // Randomised characters with random backpressure
        rdy_mode = 1;
        for (int k = 0; k < 6; k++)
            run_char(6'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        rdy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
